// File: rtl/pulse_decoder_pkg.sv
// rtl/pulse_decoder_pkg.sv - shared types and constants for the step-pulse decoder
// Contents:
//   pulse_dec_state_t : decoder FSM state encoding
//   SYNC_STAGES       : depth of the input synchroniser on the pulse line
package pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    REPORT = 2'd3
  } pulse_dec_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_decoder_fsm.sv
// rtl/pulse_decoder_fsm.sv - burst-tracking state machine for the step-pulse decoder
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : tick enable; all transitions except the REPORT exit wait for it
//   s_i            : synchronised pulse line
//   timeout_hit_i  : the current low tick completes the idle timeout
//   ack_i          : consumer accepts the report (acts on any clock edge in REPORT)
//   start_o        : first rising edge of a burst seen this tick
//   rise_o         : rising edge of a subsequent pulse seen this tick
//   fall_o         : falling edge seen this tick
//   report_o       : registered, high while the burst report is held
//   busy_o         : registered, high while a burst is in progress
//   state_o        : current state, for per-phase counting in the datapath
module pulse_decoder_fsm
  import pulse_decoder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             s_i,
  input  logic             timeout_hit_i,
  input  logic             ack_i,
  output logic             start_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             report_o,
  output logic             busy_o,
  output pulse_dec_state_t state_o
);

  pulse_dec_state_t state_q;
  logic             report_q;
  logic             busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      report_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && s_i) begin
            state_q <= HIGH;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (en_i && !s_i) begin
            state_q <= LOW;
          end
        end
        LOW: begin
          // A high sample always means another pulse; only a low sample can time out.
          if (en_i && s_i) begin
            state_q <= HIGH;
          end else if (en_i && timeout_hit_i) begin
            state_q  <= REPORT;
            busy_q   <= 1'b0;
            report_q <= 1'b1;
          end
        end
        REPORT: begin
          if (ack_i) begin
            state_q  <= IDLE;
            report_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          report_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign start_o  = en_i && s_i && (state_q == IDLE);
  assign rise_o   = en_i && s_i && (state_q == LOW);
  assign fall_o   = en_i && !s_i && (state_q == HIGH);
  assign report_o = report_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: rtl/pulse_decoder.sv
// rtl/pulse_decoder.sv - step-pulse burst decoder: recovers pulse count and width, flags malformed bursts
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   en_i            : tick enable for sampling and counting
//   in_i            : asynchronous pulse line
//   idle_timeout_i  : consecutive low ticks that end a burst (0 behaves as 1)
//   ack_i           : consumer accepts the report
//   pulse_num_o     : pulses in the reported burst
//   pulse_width_o   : high width of the first pulse, in ticks
//   valid_o         : report available
//   err_o           : burst malformed, qualified by valid_o
//   busy_o          : burst in progress
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int PULSE_NUM_BITS   = 8,
  parameter int PULSE_WIDTH_BITS = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        in_i,
  input  logic [PULSE_WIDTH_BITS:0]   idle_timeout_i,
  input  logic                        ack_i,
  output logic [PULSE_NUM_BITS-1:0]   pulse_num_o,
  output logic [PULSE_WIDTH_BITS-1:0] pulse_width_o,
  output logic                        valid_o,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam logic [PULSE_NUM_BITS-1:0]   NUM_ONE  = PULSE_NUM_BITS'(1);
  localparam logic [PULSE_NUM_BITS-1:0]   NUM_MAX  = '1;
  localparam logic [PULSE_WIDTH_BITS-1:0] HCNT_ONE = PULSE_WIDTH_BITS'(1);
  localparam logic [PULSE_WIDTH_BITS-1:0] HCNT_MAX = '1;
  localparam logic [PULSE_WIDTH_BITS:0]   LCNT_ONE = (PULSE_WIDTH_BITS + 1)'(1);
  localparam logic [PULSE_WIDTH_BITS:0]   LCNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [PULSE_NUM_BITS-1:0]   num_q,   num_d;
  logic [PULSE_WIDTH_BITS-1:0] hcnt_q,  hcnt_d;
  logic [PULSE_WIDTH_BITS:0]   lcnt_q,  lcnt_d;
  logic [PULSE_WIDTH_BITS-1:0] width_q, width_d;
  logic                        first_q, first_d;
  logic                        err_q,   err_d;

  logic [PULSE_WIDTH_BITS:0] threshold;
  logic [PULSE_WIDTH_BITS:0] lcnt_inc;
  logic                      timeout_hit;
  logic                      start, rise, fall, report;
  pulse_dec_state_t          state;
  logic                      high_tick, low_tick;

  // Synchroniser runs every clock; en only gates where its output is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end
  assign s = sync_q[SYNC_STAGES-1];

  // lcnt already counts the falling-edge tick, so the timeout fires on the
  // tick that would make the run of low ticks equal to the threshold.
  assign threshold   = (idle_timeout_i == '0) ? LCNT_ONE : idle_timeout_i;
  assign lcnt_inc    = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + LCNT_ONE;
  assign timeout_hit = (lcnt_inc >= threshold);

  pulse_decoder_fsm u_fsm (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .s_i           (s),
    .timeout_hit_i (timeout_hit),
    .ack_i         (ack_i),
    .start_o       (start),
    .rise_o        (rise),
    .fall_o        (fall),
    .report_o      (report),
    .busy_o        (busy_o),
    .state_o       (state)
  );

  assign high_tick = en_i && s && (state == HIGH);
  assign low_tick  = en_i && !s && (state == LOW);

  always_comb begin
    num_d   = num_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    width_d = width_q;
    first_d = first_q;
    err_d   = err_q;

    if (report && ack_i) begin
      num_d   = '0;
      hcnt_d  = '0;
      lcnt_d  = '0;
      width_d = '0;
      first_d = 1'b0;
      err_d   = 1'b0;
    end else if (start) begin
      num_d   = NUM_ONE;
      hcnt_d  = HCNT_ONE;
      lcnt_d  = '0;
      first_d = 1'b1;
    end else if (high_tick) begin
      if (hcnt_q == HCNT_MAX) begin
        err_d = 1'b1;
      end else begin
        hcnt_d = hcnt_q + HCNT_ONE;
      end
    end else if (fall) begin
      // The first pulse defines the reference width for every later phase.
      if (first_q) begin
        width_d = hcnt_q;
        first_d = 1'b0;
      end else if (hcnt_q != width_q) begin
        err_d = 1'b1;
      end
      lcnt_d = LCNT_ONE;
    end else if (rise) begin
      if (lcnt_q != {1'b0, width_q}) begin
        err_d = 1'b1;
      end
      if (num_q == NUM_MAX) begin
        err_d = 1'b1;
      end else begin
        num_d = num_q + NUM_ONE;
      end
      hcnt_d = HCNT_ONE;
    end else if (low_tick) begin
      lcnt_d = lcnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_q   <= '0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      width_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      num_q   <= num_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      width_q <= width_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign pulse_num_o   = num_q;
  assign pulse_width_o = width_q;
  assign valid_o       = report;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pulse_decoder.sv
// tb/tb_pulse_decoder.sv - directed self-checking bench for pulse_decoder
module tb_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_l;
  logic [8:0] idle_timeout;
  logic       ack;
  logic [7:0] pulse_num;
  logic [7:0] pulse_width;
  logic       valid;
  logic       err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int en_div = 1;

  always #5 clk = ~clk;

  pulse_decoder #(
    .PULSE_NUM_BITS   (8),
    .PULSE_WIDTH_BITS (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .in_i           (in_l),
    .idle_timeout_i (idle_timeout),
    .ack_i          (ack),
    .pulse_num_o    (pulse_num),
    .pulse_width_o  (pulse_width),
    .valid_o        (valid),
    .err_o          (err),
    .busy_o         (busy)
  );

  // Drive the line at level v for n ticks; each tick is en_div clocks with en on the first.
  task automatic tick_n(input logic v, input int n);
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < en_div; c++) begin
        in_l = v;
        en   = (c == 0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    tick_n(1'b1, hi);
    tick_n(1'b0, lo);
  endtask

  task automatic wait_valid(input int max_ticks);
    for (int i = 0; i < max_ticks; i++) begin
      if (valid === 1'b1) break;
      tick_n(1'b0, 1);
    end
    n_cmp++;
    if (valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_valid: valid=%0b after %0d ticks, required 1", valid, max_ticks);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; in_l = 1'b0; ack = 1'b0; idle_timeout = 9'd16;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b required 0", err); end
    n_cmp++; if (pulse_num !== 8'd0) begin n_bad++; $display("FAIL reset_num: got %0d required 0", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd0) begin n_bad++; $display("FAIL reset_width: got %0d required 0", pulse_width); end
    rst_n = 1'b1;
    tick_n(1'b0, 2);
  endtask

  task automatic test_clean_burst();
    en_div = 1; idle_timeout = 9'd16;
    pulse(4, 4);
    pulse(4, 4);
    tick_n(1'b1, 4);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy: got %0b required 1", busy); end
    tick_n(1'b0, 10);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL clean_early_valid: got %0b required 0", valid); end
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd3) begin n_bad++; $display("FAIL clean_num: got %0d required 3", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd4) begin n_bad++; $display("FAIL clean_width: got %0d required 4", pulse_width); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clean_err: got %0b required 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clean_busy_report: got %0b required 0", busy); end
    do_ack();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL clean_ack_valid: got %0b required 0", valid); end
    tick_n(1'b0, 2);
  endtask

  task automatic test_gated_tick();
    en_div = 2; idle_timeout = 9'd16;
    pulse(4, 4);
    tick_n(1'b1, 4);
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd2) begin n_bad++; $display("FAIL gated_num: got %0d required 2", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd4) begin n_bad++; $display("FAIL gated_width: got %0d required 4", pulse_width); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL gated_err: got %0b required 0", err); end
    do_ack();
    en_div = 1;
    tick_n(1'b0, 2);
  endtask

  task automatic test_width_mismatch();
    en_div = 1; idle_timeout = 9'd16;
    pulse(4, 4);
    pulse(5, 4);
    tick_n(1'b1, 4);
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd3) begin n_bad++; $display("FAIL hi_mis_num: got %0d required 3", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd4) begin n_bad++; $display("FAIL hi_mis_width: got %0d required 4", pulse_width); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL hi_mis_err: got %0b required 1", err); end
    do_ack();
    tick_n(1'b0, 2);
    pulse(4, 6);
    tick_n(1'b1, 4);
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd2) begin n_bad++; $display("FAIL lo_mis_num: got %0d required 2", pulse_num); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL lo_mis_err: got %0b required 1", err); end
    do_ack();
    tick_n(1'b0, 2);
  endtask

  task automatic test_saturation();
    en_div = 1; idle_timeout = 9'd16;
    for (int p = 0; p < 256; p++) pulse(1, 1);
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd255) begin n_bad++; $display("FAIL sat_num: got %0d required 255", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd1) begin n_bad++; $display("FAIL sat_num_width: got %0d required 1", pulse_width); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sat_num_err: got %0b required 1", err); end
    do_ack();
    tick_n(1'b0, 2);
    tick_n(1'b1, 300);
    wait_valid(40);
    n_cmp++; if (pulse_width !== 8'd255) begin n_bad++; $display("FAIL sat_width: got %0d required 255", pulse_width); end
    n_cmp++; if (pulse_num !== 8'd1) begin n_bad++; $display("FAIL sat_width_num: got %0d required 1", pulse_num); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sat_width_err: got %0b required 1", err); end
    do_ack();
    tick_n(1'b0, 2);
  endtask

  task automatic test_handshake();
    logic stable;
    en_div = 1; idle_timeout = 9'd16;
    tick_n(1'b1, 3);
    wait_valid(40);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_l = ((i / 3) % 2) == 0;
      en   = 1'b1;
      @(posedge clk);
      #1;
      if (valid !== 1'b1 || pulse_num !== 8'd1 || pulse_width !== 8'd3 || busy !== 1'b0 || err !== 1'b0)
        stable = 1'b0;
    end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL hs_stable: report changed while unacked (num=%0d width=%0d valid=%0b busy=%0b), required held", pulse_num, pulse_width, valid, busy); end
    tick_n(1'b0, 4);
    do_ack();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL hs_ack_valid: got %0b required 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hs_ack_busy: got %0b required 0", busy); end
    pulse(2, 2);
    tick_n(1'b1, 2);
    wait_valid(40);
    n_cmp++; if (pulse_num !== 8'd2) begin n_bad++; $display("FAIL hs_next_num: got %0d required 2", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd2) begin n_bad++; $display("FAIL hs_next_width: got %0d required 2", pulse_width); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hs_next_err: got %0b required 0", err); end
    do_ack();
    tick_n(1'b0, 2);
  endtask

  task automatic test_reset_mid_burst();
    en_div = 1; idle_timeout = 9'd16;
    pulse(3, 3);
    pulse(3, 3);
    tick_n(1'b1, 1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %0b required 1", busy); end
    in_l = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b required 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %0b required 0", busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_n(1'b0, 4);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_report: got %0b required 0", valid); end
    idle_timeout = 9'd0;
    tick_n(1'b1, 3);
    wait_valid(6);
    n_cmp++; if (pulse_num !== 8'd1) begin n_bad++; $display("FAIL mid_next_num: got %0d required 1", pulse_num); end
    n_cmp++; if (pulse_width !== 8'd3) begin n_bad++; $display("FAIL mid_next_width: got %0d required 3", pulse_width); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_next_err: got %0b required 0", err); end
    do_ack();
    tick_n(1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_clean_burst();
    test_gated_tick();
    test_width_mismatch();
    test_saturation();
    test_handshake();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
